// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the miniRISC load/store unit.
//   - access size codes (byte/half/word/illegal)
//   - FSM state encoding
//   - byte-enable generation, store-lane replication and alignment check
//   - width of the bus wait counter
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam int TO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  // Byte enables for an access of the given size at the given byte offset.
  // Loads use the same enables as a store of equal size.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the byte enables alone pick
  // the destination bytes.
  function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      SIZE_BYTE: w = {4{wdata[7:0]}};
      SIZE_HALF: w = {2{wdata[15:0]}};
      default:   w = wdata;
    endcase
    return w;
  endfunction

  // Illegal size is treated as misaligned at any address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = off[0];
      SIZE_WORD: m = (off != 2'b00);
      default:   m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data aligner.
// Ports:
//   rdata    in  32  word returned by the data bus
//   byte_off in  2   byte offset of the load address
//   size     in  2   access size code (lsu_pkg SIZE_*)
//   sign_ext in  1   1 = sign-extend, 0 = zero-extend
//   result   out 32  right-justified, extended load value
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] lane;

  // Shift the addressed byte down to bit 0, then truncate and extend.
  always_comb begin
    lane   = rdata >> {byte_off, 3'b000};
    result = lane;
    case (size)
      SIZE_BYTE: result = {{24{sign_ext & lane[7]}}, lane[7:0]};
      SIZE_HALF: result = {{16{sign_ext & lane[15]}}, lane[15:0]};
      default:   result = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage of the miniRISC core. Runs one data-bus
// transaction per request using a req/ack handshake, aligns load data and
// holds the pipeline (req_ready low) while a transaction is outstanding.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake from execute
//   req_load/size/signed    access type, size code, load extension
//   req_addr/req_wdata      byte address, right-justified store data
//   mem_req/we/be/addr/wdata  bus request, held until ack or timeout
//   mem_ack/mem_rdata       bus completion and read word
//   ld_data                 last successful load result
//   done/misalign/bus_err   one-cycle completion pulse and error flags
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  lsu_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;
  logic [31:0]     ld_data_q, ld_data_d;
  logic [31:0]     aligned;

  load_align u_align (
    .rdata    (mem_rdata),
    .byte_off (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (signed_q),
    .result   (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= SIZE_BYTE;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      ld_data_q <= ld_data_d;
    end
  end

  // The request register is only written in IDLE, so the bus signals it
  // drives stay constant for the whole ACCESS state. An ack in the cycle
  // the counter reaches TIMEOUT is checked first and therefore wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    signed_d  = signed_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    berr_d    = berr_q;
    ld_data_d = ld_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          we_d     = ~req_load;
          be_d     = be_gen(req_size, req_addr[1:0]);
          wdata_d  = wdata_gen(req_size, req_wdata);
          mis_d    = is_misaligned(req_size, req_addr[1:0]);
          berr_d   = 1'b0;
          cnt_d    = '0;
          state_d  = mis_d ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_RESP;
          if (!we_q) begin
            ld_data_d = aligned;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          berr_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign ld_data   = ld_data_q;
  assign done      = (state_q == ST_RESP);
  assign misalign  = done & mis_q;
  assign bus_err   = done & berr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a short bus timeout so the
// timeout path is reachable in a few cycles.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic        reqLoad;
   logic [1:0]  reqSize;
   logic        reqSigned;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        memReq;
   logic        memWe;
   logic [3:0]  memBe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic        memAck;
   logic [31:0] memRdata;
   logic [31:0] ldData;
   logic        done;
   logic        misalign;
   logic        busErr;

   int checkCount = 0;
   int passCount  = 0;
   int reqCycles;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid),
      .req_ready  (reqReady),
      .req_load   (reqLoad),
      .req_size   (reqSize),
      .req_signed (reqSigned),
      .req_addr   (reqAddr),
      .req_wdata  (reqWdata),
      .mem_req    (memReq),
      .mem_we     (memWe),
      .mem_be     (memBe),
      .mem_addr   (memAddr),
      .mem_wdata  (memWdata),
      .mem_ack    (memAck),
      .mem_rdata  (memRdata),
      .ld_data    (ldData),
      .done       (done),
      .misalign   (misalign),
      .bus_err    (busErr)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so a stuck design still ends the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
   endtask

   // Advance to just after the next rising edge
   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single accepting edge
   task automatic applyStimulus(input logic load, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
      reqValid  = 1'b1;
      reqLoad   = load;
      reqSize   = size;
      reqSigned = sgn;
      reqAddr   = addr;
      reqWdata  = wdata;
      waitCycle();
      reqValid  = 1'b0;
   endtask

   // Hold ack low for 'waits' ACCESS cycles, then ack with rdata.
   // Counts how many of those cycles actually had mem_req high.
   task automatic ackAfter(input int waits, input logic [31:0] rdata, output int nReq);
      nReq = 0;
      for (int i = 0; i < waits; i++) begin
         if (memReq) nReq++;
         waitCycle();
      end
      memAck   = 1'b1;
      memRdata = rdata;
      if (memReq) nReq++;
      waitCycle();
      memAck   = 1'b0;
      memRdata = 32'h0;
   endtask

   initial begin
      rst       = 1'b1;
      reqValid  = 1'b0;
      reqLoad   = 1'b0;
      reqSize   = 2'b00;
      reqSigned = 1'b0;
      reqAddr   = 32'h0;
      reqWdata  = 32'h0;
      memAck    = 1'b0;
      memRdata  = 32'h0;

      // Reset state
      #12;
      checkOutput("rst_ready",  {31'b0, reqReady}, 32'd1);
      checkOutput("rst_memreq", {31'b0, memReq},   32'd0);
      checkOutput("rst_done",   {31'b0, done},     32'd0);
      checkOutput("rst_be",     {28'b0, memBe},    32'd0);
      checkOutput("rst_addr",   memAddr,           32'h0);
      checkOutput("rst_lddata", ldData,            32'h0);
      @(negedge clk);
      rst = 1'b0;
      waitCycle();

      // 1. LW 0x100, two wait cycles
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
      checkOutput("lw_memreq", {31'b0, memReq},   32'd1);
      checkOutput("lw_ready",  {31'b0, reqReady}, 32'd0);
      checkOutput("lw_be",     {28'b0, memBe},    32'hF);
      checkOutput("lw_addr",   memAddr,           32'h100);
      checkOutput("lw_we",     {31'b0, memWe},    32'd0);
      ackAfter(2, 32'hDEADBEEF, reqCycles);
      checkOutput("lw_reqcyc", reqCycles,         32'd3);
      checkOutput("lw_done",   {31'b0, done},     32'd1);
      checkOutput("lw_memreq_off", {31'b0, memReq}, 32'd0);
      checkOutput("lw_data",   ldData,            32'hDEADBEEF);
      waitCycle();
      checkOutput("lw_ready_back", {31'b0, reqReady}, 32'd1);
      checkOutput("lw_done_off",   {31'b0, done},     32'd0);

      // 2. LB signed / LBU at 0x103
      applyStimulus(1'b1, 2'b00, 1'b1, 32'h103, 32'h0);
      checkOutput("lb_be", {28'b0, memBe}, 32'h8);
      ackAfter(0, 32'h80FF1234, reqCycles);
      checkOutput("lb_data", ldData, 32'hFFFFFF80);
      waitCycle();
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h103, 32'h0);
      ackAfter(0, 32'h80FF1234, reqCycles);
      checkOutput("lbu_data", ldData, 32'h00000080);
      waitCycle();

      // LH signed at 0x102: upper half selected and sign-extended
      applyStimulus(1'b1, 2'b01, 1'b1, 32'h102, 32'h0);
      checkOutput("lh_be", {28'b0, memBe}, 32'hC);
      ackAfter(1, 32'h80011234, reqCycles);
      checkOutput("lh_data", ldData, 32'hFFFF8001);
      waitCycle();

      // 3. SH 0x202
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
      checkOutput("sh_we",    {31'b0, memWe}, 32'd1);
      checkOutput("sh_be",    {28'b0, memBe}, 32'hC);
      checkOutput("sh_wdata", memWdata,       32'hABCDABCD);
      checkOutput("sh_addr",  memAddr,        32'h200);
      ackAfter(1, 32'h12345678, reqCycles);
      checkOutput("sh_done",  {31'b0, done},  32'd1);
      checkOutput("sh_lddata", ldData,        32'hFFFF8001);
      waitCycle();

      // SB 0x001: byte replicated into all lanes
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h001, 32'h000000A5);
      checkOutput("sb_be",    {28'b0, memBe}, 32'h2);
      checkOutput("sb_wdata", memWdata,       32'hA5A5A5A5);
      ackAfter(0, 32'h0, reqCycles);
      waitCycle();

      // 4. Misaligned / illegal requests
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h101, 32'h0);
      checkOutput("mis_lw_done",   {31'b0, done},     32'd1);
      checkOutput("mis_lw_flag",   {31'b0, misalign}, 32'd1);
      checkOutput("mis_lw_memreq", {31'b0, memReq},   32'd0);
      waitCycle();
      checkOutput("mis_lw_ready",  {31'b0, reqReady}, 32'd1);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h001, 32'h1111);
      checkOutput("mis_sh_flag",   {31'b0, misalign}, 32'd1);
      checkOutput("mis_sh_memreq", {31'b0, memReq},   32'd0);
      waitCycle();
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h000, 32'h0);
      checkOutput("ill_flag",      {31'b0, misalign}, 32'd1);
      checkOutput("ill_done",      {31'b0, done},     32'd1);
      checkOutput("ill_memreq",    {31'b0, memReq},   32'd0);
      checkOutput("ill_lddata",    ldData,            32'hFFFF8001);
      waitCycle();
      checkOutput("ill_memreq2",   {31'b0, memReq},   32'd0);

      // 5. Timeout without ack: mem_req high for TIMEOUT+1 cycles
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h500, 32'h0);
      reqCycles = 0;
      while (memReq && reqCycles < 20) begin
         reqCycles++;
         waitCycle();
      end
      checkOutput("to_reqcyc", reqCycles,        32'd5);
      checkOutput("to_done",   {31'b0, done},    32'd1);
      checkOutput("to_buserr", {31'b0, busErr},  32'd1);
      checkOutput("to_lddata", ldData,           32'hFFFF8001);
      waitCycle();
      checkOutput("to_buserr_off", {31'b0, busErr}, 32'd0);

      // Ack on the final cycle wins over the timeout
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h300, 32'h0);
      ackAfter(4, 32'h11223344, reqCycles);
      checkOutput("toack_reqcyc", reqCycles,       32'd5);
      checkOutput("toack_done",   {31'b0, done},   32'd1);
      checkOutput("toack_buserr", {31'b0, busErr}, 32'd0);
      checkOutput("toack_data",   ldData,          32'h11223344);
      waitCycle();

      // 6. Reset in the middle of ACCESS
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h400, 32'h0);
      waitCycle();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstmid_memreq", {31'b0, memReq},   32'd0);
      checkOutput("rstmid_ready",  {31'b0, reqReady}, 32'd1);
      checkOutput("rstmid_done",   {31'b0, done},     32'd0);
      @(negedge clk);
      rst    = 1'b0;
      memAck = 1'b1;
      memRdata = 32'h55555555;
      waitCycle();
      memAck = 1'b0;
      checkOutput("rstmid_lateack_done", {31'b0, done}, 32'd0);
      checkOutput("rstmid_lddata",       ldData,        32'h0);

      // A following LW completes normally (zero-wait)
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h104, 32'h0);
      checkOutput("post_addr", memAddr, 32'h104);
      ackAfter(0, 32'hCAFEF00D, reqCycles);
      checkOutput("post_done", {31'b0, done}, 32'd1);
      checkOutput("post_data", ldData,        32'hCAFEF00D);
      waitCycle();
      checkOutput("post_ready", {31'b0, reqReady}, 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
